// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, frame-config layout and helpers for uart_tx_scheduler
package uart_pkg;

  localparam int DATA_W       = 9;
  localparam int CFG_W        = 6;
  localparam int UART_CFG_W   = 7;
  localparam int CFG_WS_LSB   = 0;
  localparam int CFG_WS_W     = 4;
  localparam int CFG_PAR_BIT  = 4;
  localparam int CFG_STOP_BIT = 5;

  localparam logic [CFG_WS_W-1:0] WS_MIN = 4'd5;
  localparam logic [CFG_WS_W-1:0] WS_MAX = 4'd9;

  typedef struct packed {
    logic                n_stop;
    logic                parity_en;
    logic [CFG_WS_W-1:0] word_size;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{n_stop: 1'b0, parity_en: 1'b0, word_size: 4'd8};

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_CFG       = 5'b00010,
    ST_SEND      = 5'b00100,
    ST_WAIT_ACK  = 5'b01000,
    ST_WAIT_DONE = 5'b10000
  } state_t;

  function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] raw);
    cfg_t c;
    c.n_stop    = raw[CFG_STOP_BIT];
    c.parity_en = raw[CFG_PAR_BIT];
    c.word_size = raw[CFG_WS_LSB +: CFG_WS_W];
    if (c.word_size < WS_MIN) begin
      c.word_size = WS_MIN;
    end else if (c.word_size > WS_MAX) begin
      c.word_size = WS_MAX;
    end
    return c;
  endfunction

  // uart_tx config word: frame fields above the store-config strobe in bit 0
  function automatic logic [UART_CFG_W-1:0] uart_cfg_word(input cfg_t c, input logic store);
    return {c, store};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  last,
  output logic [N_PORTS-1:0] grant,
  output logic [PORT_W-1:0]  grant_idx,
  output logic               any
);

  localparam logic [PORT_W:0] N_EXT = (PORT_W+1)'(N_PORTS);

  logic [PORT_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    // last itself is visited at i == N_PORTS, so a lone requester still wins
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = {1'b0, last} + (PORT_W+1)'(i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!any && req[cand[PORT_W-1:0]]) begin
        any                      = 1'b1;
        grant_idx                = cand[PORT_W-1:0];
        grant[cand[PORT_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one uart_tx among N_PORTS requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_PORTS-1:0]        i_req_valid,
  input  logic [DATA_W*N_PORTS-1:0] i_req_data,
  output logic [N_PORTS-1:0]        o_req_ready,
  input  logic                      i_cfg_wr,
  input  logic [PORT_W-1:0]         i_cfg_port,
  input  logic [CFG_W-1:0]          i_cfg,
  output logic [UART_CFG_W-1:0]     o_uart_config,
  output logic [DATA_W-1:0]         o_uart_data,
  output logic                      o_uart_valid,
  input  logic                      i_uart_ready,
  output logic [PORT_W-1:0]         o_grant_id,
  output logic                      o_busy
);

  localparam logic [PORT_W:0]   N_EXT     = (PORT_W+1)'(N_PORTS);
  localparam logic [PORT_W-1:0] LAST_INIT = PORT_W'(N_PORTS-1);

  state_t             state_q, state_d;
  cfg_t               cfg_table_q [N_PORTS];
  cfg_t               active_cfg_q, sel_cfg_q, win_cfg;
  logic [DATA_W-1:0]  data_q, win_data, uart_data_q;
  logic [PORT_W-1:0]  last_q, grant_id_q, arb_idx;
  logic [N_PORTS-1:0] arb_grant;
  logic               arb_any, accept;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .PORT_W  (PORT_W)
  ) u_arb (
    .req       (i_req_valid),
    .last      (last_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign win_data = i_req_data[arb_idx*DATA_W +: DATA_W];
  assign win_cfg  = cfg_table_q[arb_idx];
  // gating with reset keeps accept pulses off while uart_tx is also held in reset
  assign accept   = i_rst_n && (state_q == ST_IDLE) && i_uart_ready && arb_any;

  always_comb begin
    state_d       = state_q;
    o_req_ready   = '0;
    o_uart_valid  = 1'b0;
    o_uart_config = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          o_req_ready = arb_grant;
          state_d     = (win_cfg != active_cfg_q) ? ST_CFG : ST_SEND;
        end
      end
      ST_CFG: begin
        o_uart_config = uart_cfg_word(sel_cfg_q, 1'b1);
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        o_uart_valid = 1'b1;
        state_d      = ST_WAIT_ACK;
      end
      // uart_tx still shows ready here because it drops it a cycle after sampling valid
      ST_WAIT_ACK: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_uart_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      active_cfg_q <= CFG_DEFAULT;
      sel_cfg_q    <= CFG_DEFAULT;
      data_q       <= '0;
      uart_data_q  <= '0;
      last_q       <= LAST_INIT;
      grant_id_q   <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        cfg_table_q[k] <= CFG_DEFAULT;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q     <= win_data;
        sel_cfg_q  <= win_cfg;
        grant_id_q <= arb_idx;
        last_q     <= arb_idx;
      end
      if (state_q == ST_CFG) begin
        active_cfg_q <= sel_cfg_q;
      end
      // data output only moves on entry to SEND so it holds between frames
      if (state_d == ST_SEND) begin
        uart_data_q <= (state_q == ST_CFG) ? data_q : win_data;
      end
      if (i_cfg_wr && ({1'b0, i_cfg_port} < N_EXT)) begin
        cfg_table_q[i_cfg_port] <= clamp_cfg(i_cfg);
      end
    end
  end

  assign o_uart_data = uart_data_q;
  assign o_grant_id  = grant_id_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized and directed checks of uart_tx_scheduler against a timeline model
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [9*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           cfg_wr;
  logic [PW-1:0]  cfg_port;
  logic [5:0]     cfg;
  logic [6:0]     uart_config;
  logic [8:0]     uart_data;
  logic           uart_valid;
  logic           uart_ready;
  logic [PW-1:0]  grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_PORTS(N), .PORT_W(PW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_cfg_wr      (cfg_wr),
    .i_cfg_port    (cfg_port),
    .i_cfg         (cfg),
    .o_uart_config (uart_config),
    .o_uart_data   (uart_data),
    .o_uart_valid  (uart_valid),
    .i_uart_ready  (uart_ready),
    .o_grant_id    (grant_id),
    .o_busy        (busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // model: table, loaded cfg, rr pointer, and the cycle numbers of the next cfg/send events
  logic [5:0] m_tab [N];
  logic [5:0] m_active, m_sel;
  logic [8:0] m_pend, m_out;
  int         m_last, m_gid, m_cfg_at, m_send_at, m_wait_from;
  bit         m_free;
  bit         armed = 1'b0;

  int u_lo = 0, u_hi = 0, frame_len = 8, drop_pct = 0;
  bit         pend [N];
  logic [8:0] pdata [N];
  bit         rand_mode = 1'b0, refill_all = 1'b0;

  int acc_port[$], acc_cyc[$], sent_q[$], sent_cyc[$], cfg_q[$], cfg_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] r);
    int ws;
    ws = int'(r[3:0]);
    if (ws < 5) ws = 5;
    if (ws > 9) ws = 9;
    return {r[5:4], 4'(ws)};
  endfunction

  function automatic int find_win(input logic [N-1:0] v, input int last);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_tab[k] = 6'h08;
    m_active = 6'h08; m_sel = 6'h08; m_pend = '0; m_out = '0;
    m_last = N - 1; m_gid = 0; m_free = 1'b1;
    m_cfg_at = -1; m_send_at = -1; m_wait_from = -1;
    u_lo = 0; u_hi = 0;
  endtask

  task automatic clear_logs();
    acc_port.delete(); acc_cyc.delete(); sent_q.delete();
    sent_cyc.delete(); cfg_q.delete(); cfg_cyc.delete();
  endtask

  task automatic gen();
    if (rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(99) < 30) begin pend[k] = 1'b1; pdata[k] = 9'($urandom_range(511)); end
        end else if ($urandom_range(99) < 3) pend[k] = 1'b0;
      end
      cfg_wr    = ($urandom_range(99) < 5);
      cfg_port  = PW'($urandom_range(N - 1));
      cfg       = 6'($urandom_range(63));
      rst_n     = ($urandom_range(999) >= 3);
      frame_len = $urandom_range(6, 1);
    end
    if (refill_all) begin
      for (int k = 0; k < N; k++)
        if (!pend[k]) begin pend[k] = 1'b1; pdata[k] = 9'($urandom_range(511)); end
    end
    for (int k = 0; k < N; k++) begin
      req_valid[k]      = pend[k];
      req_data[9*k +: 9] = pend[k] ? pdata[k] : 9'($urandom_range(511));
    end
    uart_ready = !(cyc >= u_lo && cyc < u_hi) &&
                 !(m_free && drop_pct > 0 && $urandom_range(99) < drop_pct);
  endtask

  task automatic compare();
    int w;
    logic [N-1:0] er;
    logic [6:0] ec;
    w  = find_win(req_valid, m_last);
    er = '0;
    if (rst_n && m_free && uart_ready && w >= 0) er[w] = 1'b1;
    ec = (cyc == m_cfg_at) ? {m_sel, 1'b1} : 7'd0;
    chk("req_ready", req_ready, er);
    chk("uart_valid", uart_valid, (cyc == m_send_at));
    chk("uart_config", uart_config, ec);
    chk("uart_data", uart_data, (cyc == m_send_at) ? m_pend : m_out);
    chk("busy", busy, !m_free);
    chk("grant_id", grant_id, m_gid);
  endtask

  task automatic log_events();
    if (armed && rst_n) begin
      for (int k = 0; k < N; k++)
        if (req_ready[k]) begin acc_port.push_back(k); acc_cyc.push_back(cyc); end
      if (uart_valid) begin sent_q.push_back(int'(uart_data)); sent_cyc.push_back(cyc); end
      if (uart_config[0]) begin cfg_q.push_back(int'(uart_config)); cfg_cyc.push_back(cyc); end
    end
  endtask

  task automatic step();
    int w;
    bit nf;
    if (!rst_n) begin
      model_reset();
      armed = 1'b1;
    end else begin
      w  = find_win(req_valid, m_last);
      nf = m_free;
      if (cyc == m_send_at) m_out = m_pend;
      if (!m_free && m_wait_from >= 0 && cyc >= m_wait_from && uart_ready) nf = 1'b1;
      if (m_free && uart_ready && w >= 0) begin
        m_sel = m_tab[w];
        if (m_sel != m_active) begin
          m_cfg_at = cyc + 1; m_send_at = cyc + 2; m_active = m_sel;
        end else begin
          m_cfg_at = -1; m_send_at = cyc + 1;
        end
        m_wait_from = m_send_at + 2;
        m_pend = req_data[9*w +: 9];
        m_gid = w; m_last = w; nf = 1'b0; pend[w] = 1'b0;
      end
      if (cfg_wr) m_tab[cfg_port] = clamp(cfg);
      m_free = nf;
      if (uart_valid && uart_ready) begin u_lo = cyc + 2; u_hi = cyc + 2 + frame_len; end
    end
    cyc++;
  endtask

  task automatic cycle();
    gen();
    #1;
    if (armed) compare();
    log_events();
    step();
    @(negedge clk);
  endtask

  task automatic run_until_sent(input int extra);
    int n0;
    n0 = sent_q.size();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sent_q.size() > n0) break;
    end
    repeat (extra) cycle();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; cfg_wr = 1'b0;
    cfg_port = '0; cfg = '0; uart_ready = 1'b1;
    for (int k = 0; k < N; k++) begin pend[k] = 1'b0; pdata[k] = '0; end
    model_reset();
    @(negedge clk);
    cycle();
    chk("reset_outputs", {req_ready, busy, uart_valid, uart_config, uart_data, grant_id}, 32'd0);
    cycle();
    rst_n = 1'b1;

    clear_logs();
    pend[0] = 1'b1; pdata[0] = 9'h0A5;
    repeat (16) cycle();
    chk("d1_accepts", acc_port.size(), 1);
    chk("d1_port", qi(acc_port, 0), 0);
    chk("d1_data", qi(sent_q, 0), 32'h0A5);
    chk("d1_latency", qi(sent_cyc, 0) - qi(acc_cyc, 0), 1);
    chk("d1_no_cfg", cfg_q.size(), 0);

    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    clear_logs();
    refill_all = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (acc_port.size() >= 5) break;
    end
    refill_all = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("fair_order_%0d", i), qi(acc_port, i), i % 4);
    repeat (16) cycle();

    clear_logs();
    cfg_wr = 1'b1; cfg_port = 2'd2; cfg = 6'b111001;
    cycle();
    cfg_wr = 1'b0;
    pend[2] = 1'b1; pdata[2] = 9'h1FF;
    repeat (16) cycle();
    chk("d3_cfg_count", cfg_q.size(), 1);
    chk("d3_cfg_word", qi(cfg_q, 0), 32'b1110011);
    chk("d3_data", qi(sent_q, 0), 32'h1FF);
    chk("d3_cfg_to_send", qi(sent_cyc, 0) - qi(cfg_cyc, 0), 1);
    chk("d3_latency", qi(sent_cyc, 0) - qi(acc_cyc, 0), 2);
    pend[2] = 1'b1; pdata[2] = 9'h055;
    repeat (16) cycle();
    chk("d3_no_second_cfg", cfg_q.size(), 1);
    chk("d3_second_data", qi(sent_q, 1), 32'h055);

    clear_logs();
    cfg_wr = 1'b1; cfg_port = 2'd1; cfg = 6'b000011;
    cycle();
    cfg_port = 2'd3; cfg = 6'b001100;
    cycle();
    cfg_wr = 1'b0;
    pend[1] = 1'b1; pdata[1] = 9'h015;
    repeat (16) cycle();
    pend[3] = 1'b1; pdata[3] = 9'h1AB;
    repeat (16) cycle();
    chk("d4_clamp_low", qi(cfg_q, 0), 32'b0001011);
    chk("d4_clamp_high", qi(cfg_q, 1), 32'b0010011);

    clear_logs();
    pend[0] = 1'b1; pdata[0] = 9'h123;
    run_until_sent(3);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("d5_outputs_after_abort", {busy, uart_valid, uart_config, uart_data, grant_id}, 32'd0);
    clear_logs();
    pend[1] = 1'b1; pdata[1] = 9'h0F0;
    repeat (16) cycle();
    chk("d5_default_cfg", cfg_q.size(), 0);
    chk("d5_data", qi(sent_q, 0), 32'h0F0);

    clear_logs();
    pend[0] = 1'b1; pdata[0] = 9'h011;
    run_until_sent(3);
    cfg_wr = 1'b1; cfg_port = 2'd0; cfg = 6'b010111;
    cycle();
    cfg_wr = 1'b0;
    repeat (14) cycle();
    chk("d6_inflight_unchanged", cfg_q.size(), 0);
    chk("d6_inflight_data", qi(sent_q, 0), 32'h011);
    pend[0] = 1'b1; pdata[0] = 9'h022;
    repeat (16) cycle();
    chk("d6_next_cfg", qi(cfg_q, 0), 32'b0101111);
    chk("d6_next_data", qi(sent_q, 1), 32'h022);

    rand_mode = 1'b1; drop_pct = 10;
    repeat (3000) cycle();
    rand_mode = 1'b0; drop_pct = 0; rst_n = 1'b1; cfg_wr = 1'b0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_tx instance among N_PORTS requesters using round-robin arbitration.
- Holds a per-port frame configuration table (word size, parity enable, stop bits).
- Reprograms the UART through its store-config strobe only when the granted port's configuration differs from the one currently loaded.
- Sits between the host-side requesters and uart_tx. It drives uart_tx's i_config, i_tx_parallel and i_tx_valid, and reads its o_ready.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- PORT_W, $clog2(N_PORTS), width of port index signals.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset, shared with uart_tx
- i_req_valid  in  N_PORTS  per-port "word pending"
- i_req_data  in  9*N_PORTS  per-port word; port k occupies bits [9k+8:9k]
- o_req_ready  out  N_PORTS  one-hot accept; word k is consumed when valid[k]&ready[k]
- i_cfg_wr  in  1  write strobe for the config table
- i_cfg_port  in  PORT_W  table index to write
- i_cfg  in  6  {n_stop[5], parity_en[4], word_size[3:0]}
- o_uart_config  out  7  to uart_tx i_config
- o_uart_data  out  9  to uart_tx i_tx_parallel
- o_uart_valid  out  1  to uart_tx i_tx_valid
- i_uart_ready  in  1  from uart_tx o_ready
- o_grant_id  out  PORT_W  port of the frame in flight or last sent
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_rst_n=0 sampled at posedge) puts the block in these values:
  - state=IDLE.
  - Every table entry = {0,0,8}; active_cfg={0,0,8}, which equals the uart_tx reset default.
  - rr pointer last=N_PORTS-1, so port 0 has highest priority first.
  - All outputs 0.
- Reset mid-frame aborts to IDLE with no accept pulses. uart_tx is reset by the same signal, so the two stay consistent.
- Config table writes:
  - i_cfg_wr writes entry i_cfg_port at posedge in any state.
  - word_size is clamped to [5,9] on write.
  - An out-of-range port index is ignored.
  - The grant uses the table value at the grant cycle. A write to an in-flight port applies from its next frame.
- FSM states: IDLE, CFG, SEND, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If i_uart_ready=1 and |i_req_valid, the winner is the first valid port searching last+1, last+2, ... (mod N_PORTS).
  - o_req_ready[winner]=1 combinationally in this cycle.
  - The block latches data, latches the winner's table entry as sel_cfg, sets o_grant_id=winner, and sets last=winner.
  - Next state: CFG if sel_cfg != active_cfg, else SEND.
  - With no request, or with i_uart_ready=0, it stays in IDLE and asserts no ready.
- CFG:
  - o_uart_config={n_stop,parity_en,word_size,1'b1} for exactly 1 cycle; o_uart_valid=0 (valid and config are never driven together).
  - active_cfg<=sel_cfg; next state SEND.
- SEND:
  - o_uart_valid=1 for exactly 1 cycle; o_uart_data=latched word; o_uart_config[0]=0.
  - Next state WAIT_ACK.
- WAIT_ACK: 1 cycle in which i_uart_ready is ignored (uart_tx clears ready one cycle after sampling valid); next state WAIT_DONE.
- WAIT_DONE: stays until i_uart_ready=1, then goes to IDLE. The next grant can happen in the IDLE cycle after that.
- Latency, from accept to o_uart_valid: 1 cycle with no reconfig, 2 cycles with reconfig.
- Fairness: a port that just won has lowest priority next round. No starvation for any continuously valid port within N_PORTS frames.
- A requester dropping valid before it is accepted is legal; no state is kept for it.
- Outside CFG, o_uart_config=0. o_uart_data holds its last value when SEND is not active.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (one-hot, 5 bits);
  - cfg field offsets and widths;
  - default cfg {0,0,8};
  - word size limits 5 and 9.
- One sub-module, rr_arbiter:
  - inputs: req[N_PORTS], last pointer;
  - outputs: one-hot grant plus encoded index;
  - purely combinational; the pointer register stays in uart_tx_scheduler.

Test Plan:
- After reset, port 0 valid with 0x0A5, table default → no CFG cycle; o_uart_valid pulses 1 cycle after accept with data 0x0A5; uart_tx serializes 8 bits LSB first, then 1 stop bit.
- Ports 0-3 all continuously valid → grant order 0,1,2,3,0; each o_req_ready is a single-cycle pulse, one per frame.
- Write port 2 cfg {1,1,9} with 0x1FF queued → CFG cycle drives o_uart_config=7'b1110011, then SEND; line shows 9 data bits, parity 1, 2 stop bits. A following frame from port 2 has no CFG cycle.
- Write word_size 3 to port 1, then 12 to port 3 → stored 5 and 9 respectively; frames carry 5 and 9 data bits.
- Assert i_rst_n=0 during TX_DATA of a frame → all outputs 0 next cycle, state IDLE; a new request afterwards is served with default cfg.
- Write cfg for a port while its frame is in WAIT_DONE → current frame unchanged; the next frame from that port triggers CFG.
